// File: rtl/hazard_sequencer_if.sv
// Handshake/control bundle between the pipeline datapath and the hazard sequencer.
// Latency: none; pure signal grouping.
// Backpressure: none at this level; the sequencer's stall outputs act as backpressure.
//
// master: pipeline side (drives hazard inputs, consumes controls)
// slave : sequencer side (consumes hazard inputs, drives controls)
interface hazard_sequencer_if;
    logic [6:0]  in_ifid_opcode;
    logic [4:0]  in_ifid_rs1;
    logic [4:0]  in_ifid_rs2;
    logic        in_idex_memread;
    logic [4:0]  in_idex_rd;
    logic        in_ex_redirect;
    logic        in_dmem_req;
    logic        in_dmem_ready;
    logic        out_pc_write;
    logic        out_ifid_write;
    logic        out_ifid_flush;
    logic        out_idex_bubble;
    logic        out_pipe_hold;
    logic [1:0]  out_state;
    logic        out_mem_err;
    logic [31:0] out_stall_cnt;
    logic [31:0] out_flush_cnt;

    modport master (
        output in_ifid_opcode, in_ifid_rs1, in_ifid_rs2, in_idex_memread, in_idex_rd,
               in_ex_redirect, in_dmem_req, in_dmem_ready,
        input  out_pc_write, out_ifid_write, out_ifid_flush, out_idex_bubble,
               out_pipe_hold, out_state, out_mem_err, out_stall_cnt, out_flush_cnt
    );

    modport slave (
        input  in_ifid_opcode, in_ifid_rs1, in_ifid_rs2, in_idex_memread, in_idex_rd,
               in_ex_redirect, in_dmem_req, in_dmem_ready,
        output out_pc_write, out_ifid_write, out_ifid_flush, out_idex_bubble,
               out_pipe_hold, out_state, out_mem_err, out_stall_cnt, out_flush_cnt
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline control sequencer: load-use stall, post-redirect IF/ID flush window, dmem freeze.
// Latency: controls are a same-cycle combinational decode of state and inputs; state moves on the edge.
// Backpressure: a pending dmem access freezes PC, IF/ID and the later pipeline registers until ready.
//
// Ports: in_clk, in_rst_n (synchronous, active-low) plus bus (hazard_sequencer_if.slave):
//   inputs  - ID opcode/rs1/rs2, EX load flag and rd, EX redirect, dmem req/ready
//   outputs - pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state, mem_err,
//             stall_cnt / flush_cnt (built only when HAZARD_SEQ_PERF_EN is defined, else 0)
module hazard_sequencer #(
    parameter int FETCH_LAT   = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 16
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    hazard_sequencer_if.slave  bus
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_FLUSH = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;

    localparam logic [2:0]      LAT    = 3'(FETCH_LAT);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    logic [1:0]      state, state_n;
    logic [1:0]      saved, saved_n;
    logic [2:0]      fcnt, fcnt_n;
    logic [TO_W-1:0] tcnt, tcnt_n;
    logic            mem_err, mem_err_n;

    logic rs1_used;
    logic rs2_used;
    logic load_use;
    logic mem_stall;
    logic redirect_ok;

    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;

    // Source-register usage: LUI/AUIPC/JAL have no rs1; only R-type, stores and branches read rs2.
    always_comb begin
        rs1_used = !((bus.in_ifid_opcode == 7'b0110111) ||
                     (bus.in_ifid_opcode == 7'b0010111) ||
                     (bus.in_ifid_opcode == 7'b1101111));
        rs2_used =  (bus.in_ifid_opcode == 7'b0110011) ||
                    (bus.in_ifid_opcode == 7'b0100011) ||
                    (bus.in_ifid_opcode == 7'b1100011);
    end

    // x0 is never a real producer, so a load to x0 cannot create a hazard.
    assign load_use = bus.in_idex_memread && (bus.in_idex_rd != 5'd0) &&
                      ((rs1_used && (bus.in_idex_rd == bus.in_ifid_rs1)) ||
                       (rs2_used && (bus.in_idex_rd == bus.in_ifid_rs2)));

    // A ready on the request cycle completes the access with no wait.
    assign mem_stall = bus.in_dmem_req && !bus.in_dmem_ready;

    // State register
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state   <= ST_RUN;
            saved   <= ST_RUN;
            fcnt    <= 3'd0;
            tcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_n;
            saved   <= saved_n;
            fcnt    <= fcnt_n;
            tcnt    <= tcnt_n;
            mem_err <= mem_err_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n     = state;
        saved_n     = saved;
        fcnt_n      = fcnt;
        tcnt_n      = tcnt;
        mem_err_n   = mem_err;
        redirect_ok = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    state_n = ST_WAIT;
                    saved_n = ST_RUN;
                    tcnt_n  = '0;
                end else if (bus.in_ex_redirect) begin
                    redirect_ok = 1'b1;
                    if (LAT != 3'd0) begin
                        state_n = ST_FLUSH;
                        fcnt_n  = LAT;
                    end
                end
            end
            ST_FLUSH: begin
                if (mem_stall) begin
                    // Flush count is frozen so the window resumes where it left off.
                    state_n = ST_WAIT;
                    saved_n = ST_FLUSH;
                    tcnt_n  = '0;
                end else if (bus.in_ex_redirect) begin
                    redirect_ok = 1'b1;
                    fcnt_n      = LAT;
                end else if (fcnt <= 3'd1) begin
                    state_n = ST_RUN;
                    fcnt_n  = 3'd0;
                end else begin
                    fcnt_n = fcnt - 3'd1;
                end
            end
            ST_WAIT: begin
                if (bus.in_dmem_ready) begin
                    state_n = saved;
                    tcnt_n  = '0;
                end else begin
                    if (tcnt != TO_MAX) begin
                        tcnt_n = tcnt + TO_W'(1);
                    end
                    if (tcnt_n == TO_MAX) begin
                        mem_err_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    // Output decode
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (!in_rst_n) begin
            // Keep NOPs flowing into the front end while reset is held.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        pipe_hold  = 1'b1;
                    end else if (bus.in_ex_redirect) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (mem_stall) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        pipe_hold  = 1'b1;
                    end else begin
                        // ID holds a bubble here, so load_use is irrelevant.
                        ifid_flush  = 1'b1;
                        idex_bubble = bus.in_ex_redirect;
                    end
                end
                ST_WAIT: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_pc_write    = pc_write;
    assign bus.out_ifid_write  = ifid_write;
    assign bus.out_ifid_flush  = ifid_flush;
    assign bus.out_idex_bubble = idex_bubble;
    assign bus.out_pipe_hold   = pipe_hold;
    assign bus.out_state       = in_rst_n ? state : ST_RUN;
    assign bus.out_mem_err     = mem_err;

`ifdef HAZARD_SEQ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!pc_write && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect_ok && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign bus.out_stall_cnt = stall_cnt;
    assign bus.out_flush_cnt = flush_cnt;
`else
    logic unused_perf;
    assign unused_perf       = redirect_ok;
    assign bus.out_stall_cnt = 32'd0;
    assign bus.out_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: two instances (FETCH_LAT 1 and 3, MEM_TIMEOUT 8) share stimulus.
// Latency: the driver pushes expected controls each cycle; the monitor compares on the falling edge.
// Backpressure: none; every cycle produces one expected/observed pair per instance.
module tb_hazard_sequencer;
    localparam int TO = 8;

    logic in_clk = 1'b0;
    logic in_rst_n;
    always #5 in_clk = ~in_clk;

    hazard_sequencer_if bus_a();
    hazard_sequencer_if bus_b();

    hazard_sequencer #(.FETCH_LAT(1), .MEM_TIMEOUT(TO), .TO_W(16)) dut_a (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .bus(bus_a));
    hazard_sequencer #(.FETCH_LAT(3), .MEM_TIMEOUT(TO), .TO_W(16)) dut_b (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .bus(bus_b));

    typedef struct packed {
        logic        pc;
        logic        ifw;
        logic        fl;
        logic        bub;
        logic        hold;
        logic [1:0]  st;
        logic        err;
        logic [31:0] sc;
        logic [31:0] fc;
    } obs_t;

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t act_a, act_b;
    int   checks = 0;
    int   fails  = 0;

    assign act_a = {bus_a.out_pc_write, bus_a.out_ifid_write, bus_a.out_ifid_flush,
                    bus_a.out_idex_bubble, bus_a.out_pipe_hold, bus_a.out_state,
                    bus_a.out_mem_err, bus_a.out_stall_cnt, bus_a.out_flush_cnt};
    assign act_b = {bus_b.out_pc_write, bus_b.out_ifid_write, bus_b.out_ifid_flush,
                    bus_b.out_idex_bubble, bus_b.out_pipe_hold, bus_b.out_state,
                    bus_b.out_mem_err, bus_b.out_stall_cnt, bus_b.out_flush_cnt};

    // Current stimulus
    logic [6:0] s_op;
    logic [4:0] s_rs1, s_rs2, s_rd;
    logic       s_mr, s_redir, s_req, s_rdy;

    // Reference model: mode 0 running, 1 flushing, 2 waiting on memory
    int          m_mode[2];
    int          m_left[2];
    int          m_ret[2];
    int          m_wait[2];
    bit          m_err[2];
    bit [31:0]   m_sc[2];
    bit [31:0]   m_fc[2];

    task automatic model_reset(input int k);
        m_mode[k] = 0; m_left[k] = 0; m_ret[k] = 0; m_wait[k] = 0;
        m_err[k] = 1'b0; m_sc[k] = 32'd0; m_fc[k] = 32'd0;
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    endfunction

    task automatic model_step(input int k, output obs_t e);
        int lat;
        bit stall, hazard, taken;
        lat    = (k == 0) ? 1 : 3;
        stall  = s_req && !s_rdy;
        hazard = s_mr && (s_rd != 0) &&
                 ((reads_rs1(s_op) && s_rd == s_rs1) || (reads_rs2(s_op) && s_rd == s_rs2));
        taken  = 1'b0;
        e      = '0;
        e.pc   = 1'b1;
        e.ifw  = 1'b1;
        e.st   = 2'(m_mode[k]);
        e.err  = m_err[k];
`ifdef HAZARD_SEQ_PERF_EN
        e.sc   = m_sc[k];
        e.fc   = m_fc[k];
`endif
        if (!in_rst_n) begin
            e.pc = 0; e.ifw = 0; e.fl = 1; e.bub = 1; e.hold = 0; e.st = 2'b00;
            model_reset(k);
            return;
        end
        if (m_mode[k] == 2) begin
            e.pc = 0; e.ifw = 0; e.hold = 1;
            if (s_rdy) begin
                m_mode[k] = m_ret[k];
                m_wait[k] = 0;
            end else begin
                if (m_wait[k] < TO) m_wait[k]++;
                if (m_wait[k] == TO) m_err[k] = 1'b1;
            end
        end else if (stall) begin
            e.pc = 0; e.ifw = 0; e.hold = 1;
            m_ret[k]  = m_mode[k];
            m_mode[k] = 2;
            m_wait[k] = 0;
        end else if (m_mode[k] == 1) begin
            e.fl = 1;
            if (s_redir) begin
                e.bub = 1; taken = 1; m_left[k] = lat;
            end else if (m_left[k] == 1) begin
                m_mode[k] = 0;
            end else begin
                m_left[k]--;
            end
        end else if (s_redir) begin
            e.fl = 1; e.bub = 1; taken = 1;
            if (lat > 0) begin
                m_mode[k] = 1; m_left[k] = lat;
            end
        end else if (hazard) begin
            e.pc = 0; e.ifw = 0; e.bub = 1;
        end
        if (!e.pc && m_sc[k] != 32'hFFFF_FFFF) m_sc[k]++;
        if (taken && m_fc[k] != 32'hFFFF_FFFF) m_fc[k]++;
    endtask

    task automatic apply_inputs();
        bus_a.in_ifid_opcode = s_op;  bus_b.in_ifid_opcode = s_op;
        bus_a.in_ifid_rs1 = s_rs1;    bus_b.in_ifid_rs1 = s_rs1;
        bus_a.in_ifid_rs2 = s_rs2;    bus_b.in_ifid_rs2 = s_rs2;
        bus_a.in_idex_memread = s_mr; bus_b.in_idex_memread = s_mr;
        bus_a.in_idex_rd = s_rd;      bus_b.in_idex_rd = s_rd;
        bus_a.in_ex_redirect = s_redir; bus_b.in_ex_redirect = s_redir;
        bus_a.in_dmem_req = s_req;    bus_b.in_dmem_req = s_req;
        bus_a.in_dmem_ready = s_rdy;  bus_b.in_dmem_ready = s_rdy;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic mr, input logic [4:0] rd, input logic redir,
                         input logic req, input logic rdy, input logic rstn);
        obs_t e;
        @(posedge in_clk);
        #1;
        s_op = op; s_rs1 = r1; s_rs2 = r2; s_mr = mr; s_rd = rd;
        s_redir = redir; s_req = req; s_rdy = rdy; in_rst_n = rstn;
        apply_inputs();
        model_step(0, e); q_a.push_back(e);
        model_step(1, e); q_b.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(7'b0010011, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
    endtask

    task automatic mem_stall(input int n);
        for (int i = 0; i < n; i++) drive(7'b0010011, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 1);
    endtask

    task automatic mem_done();
        drive(7'b0010011, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1);
    endtask

    task automatic redirect();
        drive(7'b0010011, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 1);
    endtask

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got pc=%b ifw=%b fl=%b bub=%b hold=%b st=%b err=%b sc=%0d fc=%0d | want pc=%b ifw=%b fl=%b bub=%b hold=%b st=%b err=%b sc=%0d fc=%0d",
                     name, $time, got.pc, got.ifw, got.fl, got.bub, got.hold, got.st, got.err,
                     got.sc, got.fc, exp.pc, exp.ifw, exp.fl, exp.bub, exp.hold, exp.st, exp.err,
                     exp.sc, exp.fc);
        end
    endtask

    // Monitor: one output set per instance per cycle
    always @(negedge in_clk) begin
        if (q_a.size() > 0) compare("lat1", act_a, q_a.pop_front());
        if (q_b.size() > 0) compare("lat3", act_b, q_b.pop_front());
    end

    logic [6:0] op_pool [9];

    initial begin
        op_pool = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011,
                    7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        model_reset(0);
        model_reset(1);
        s_op = 7'b0010011; s_rs1 = 0; s_rs2 = 0; s_rd = 0;
        s_mr = 0; s_redir = 0; s_req = 0; s_rdy = 0;
        in_rst_n = 1'b0;
        apply_inputs();

        // Reset values
        for (int i = 0; i < 3; i++) drive(7'b0010011, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load-use: R-type rs2 match stalls; I-type rs2 ignored; rd=x0 ignored
        drive(7'b0110011, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, 1);
        idle(1);
        drive(7'b0010011, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, 1);
        drive(7'b0110011, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 1);
        drive(7'b0110111, 5'd7, 5'd0, 1, 5'd7, 0, 0, 0, 1);
        drive(7'b0000011, 5'd7, 5'd0, 1, 5'd7, 0, 0, 0, 1);
        idle(1);

        // Redirect and flush window
        redirect();
        idle(4);

        // Memory stall: 4 waiting cycles then ready
        mem_stall(4);
        mem_done();
        idle(2);

        // Stall in the middle of a flush window
        redirect();
        idle(1);
        mem_stall(3);
        mem_done();
        idle(4);

        // Redirect while flushing reloads the window
        redirect();
        idle(1);
        redirect();
        idle(5);

        // Timeout: error is sticky past ready, cleared only by reset
        mem_stall(10);
        mem_done();
        idle(3);
        mem_stall(3);
        drive(7'b0010011, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(7'b0010011, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Two load-use stalls and three redirects from a clean reset
        drive(7'b0010011, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(7'b0110011, 5'd3, 5'd9, 1, 5'd3, 0, 0, 0, 1);
        idle(1);
        drive(7'b0100011, 5'd2, 5'd4, 1, 5'd4, 0, 0, 0, 1);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            redirect();
            idle(5);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic ready_now;
            ready_now = ($urandom_range(0, 2) != 0);
            drive(op_pool[$urandom_range(0, 8)], 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 4) == 0), ready_now, ($urandom_range(0, 199) != 0));
        end

        @(negedge in_clk);
        #1;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d/%0d expectations left, want 0", q_a.size(), q_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control sequencer for the 5-stage RISC-V core; works alongside the operand-forwarding logic.
- Detects load-use hazards the forwarding paths cannot cover.
- Sequences the IF/ID flush window after an EX-stage control redirect.
- Freezes the whole pipeline while the data-memory handshake is pending.
- Drives PC and pipeline-register write-enable, flush and bubble controls.

Parameters:
- FETCH_LAT, 1: extra cycles after the redirect cycle during which IF/ID is flushed (instruction-memory latency). Legal range 0..7.
- MEM_TIMEOUT, 255: cycles in MEM_WAIT before out_mem_err sets. Legal range 1..65535.
- TO_W, 16: width of the wait-timeout counter.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst_n  input  1  synchronous, active-low reset.
- in_ifid_opcode  input  7  opcode of the instruction in ID.
- in_ifid_rs1  input  5  rs1 field of the instruction in ID.
- in_ifid_rs2  input  5  rs2 field of the instruction in ID.
- in_idex_memread  input  1  instruction in EX is a load.
- in_idex_rd  input  5  destination register of the instruction in EX.
- in_ex_redirect  input  1  taken branch, jal or jalr resolved in EX.
- in_dmem_req  input  1  EX/MEM instruction is accessing data memory.
- in_dmem_ready  input  1  data memory completes the access this cycle.
- out_pc_write  output  1  PC update enable.
- out_ifid_write  output  1  IF/ID register load enable.
- out_ifid_flush  output  1  load NOP into IF/ID.
- out_idex_bubble  output  1  load NOP into ID/EX.
- out_pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB.
- out_state  output  2  FSM state: 00 RUN, 01 FLUSH, 10 MEM_WAIT.
- out_mem_err  output  1  sticky memory-timeout flag.
- out_stall_cnt  output  32  stall cycle counter (optional feature).
- out_flush_cnt  output  32  redirect counter (optional feature).

Behaviour:
- State, counters and out_mem_err update on the rising edge of in_clk. Outputs are a combinational decode of state and inputs.
- While in_rst_n=0 at an edge:
  - state <= RUN, flush counter <= 0, timeout counter <= 0, saved state <= RUN, out_mem_err <= 0, perf counters <= 0.
  - While in_rst_n is low, outputs are forced to: pc_write 0, ifid_write 0, ifid_flush 1, idex_bubble 1, pipe_hold 0, out_state 00.
- Reset asserted mid-operation (any state) aborts that state at the next edge. No flag survives the reset.
- Source-register usage:
  - rs1 is unused for opcodes 0110111, 0010111, 1101111.
  - rs2 is used only for opcodes 0110011, 0100011, 1100011.
- load_use = in_idex_memread && in_idex_rd!=0 && ((rs1 used && rd==rs1) || (rs2 used && rd==rs2)).
- Priority per cycle: MEM_WAIT condition, then redirect, then load_use.
- Default outputs (RUN, no event): pc_write 1, ifid_write 1, all other controls 0.
- RUN:
  - in_dmem_req && !in_dmem_ready: pc_write 0, ifid_write 0, pipe_hold 1. Saved state <= RUN; go to MEM_WAIT.
  - Else if in_ex_redirect: ifid_flush 1, idex_bubble 1, pc_write 1.
    - If FETCH_LAT>0, load the flush counter with FETCH_LAT and go to FLUSH.
    - If FETCH_LAT=0, stay in RUN.
  - Else if load_use: pc_write 0, ifid_write 0, idex_bubble 1, for exactly one cycle. No state change.
- FLUSH:
  - Outputs: pc_write 1, ifid_write 1, ifid_flush 1. load_use is ignored because ID holds a bubble.
  - Counter decrements each cycle; go to RUN on the cycle the count is 1.
  - A new in_ex_redirect reloads FETCH_LAT and asserts idex_bubble.
  - A memory stall takes priority: saved state <= FLUSH, counter frozen, go to MEM_WAIT.
- MEM_WAIT:
  - Outputs: pc_write 0, ifid_write 0, pipe_hold 1, ifid_flush 0, idex_bubble 0.
  - Redirect and load_use are ignored.
  - Timeout counter increments, saturating at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, out_mem_err <= 1; the FSM stays in MEM_WAIT.
  - When in_dmem_ready=1: hold still asserted that cycle; next state = saved state; timeout counter cleared.
  - An in_dmem_ready=1 on the same cycle as entry suppresses the wait entirely (RUN rule).
- out_mem_err clears only on reset.
- The encoding 11 is unreachable; if it is ever reached, the next state is RUN.

Optional Feature:
- Macro: HAZARD_SEQ_PERF_EN.
- Defined:
  - out_stall_cnt increments each cycle with pc_write=0 (load-use or MEM_WAIT).
  - out_flush_cnt increments on each accepted in_ex_redirect.
  - Both saturate at 32'hFFFFFFFF and are reset to 0.
- Undefined: counters are not built; both ports are tied to 0.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid opcode 0110011, rs2=5. Expect one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then RUN defaults. Repeat with opcode 0010011, rs2=5: no stall. Repeat with rd=0: no stall.
- Redirect, FETCH_LAT=1: pulse in_ex_redirect. Expect ifid_flush=1 and idex_bubble=1 that cycle, then exactly 1 more cycle of ifid_flush=1 with out_state=01, then out_state=00.
- Memory stall: dmem_req=1 with ready low for 4 cycles. Expect pipe_hold=1 and pc_write=0 for 5 cycles total including the ready cycle, out_state=10, out_mem_err=0.
- Stall inside FLUSH, FETCH_LAT=3: redirect, then dmem stall at flush cycle 2 lasting 3 cycles. Expect the return to FLUSH with 2 flush cycles remaining.
- Timeout, MEM_TIMEOUT=8: hold ready low for 10 cycles. Expect out_mem_err=1 from the 8th wait cycle and sticky after ready. Apply in_rst_n=0 during the wait: all outputs take their reset values and out_mem_err=0.
- With HAZARD_SEQ_PERF_EN: 2 load-use stalls plus 3 redirects give out_stall_cnt=2 and out_flush_cnt=3. Without the macro, both read 0.
